// File: rtl/ram_rd_streamer_pkg.sv
// Shared constants and types for the RAM read streamer.
//   FIFO_DEPTH : words of elastic storage between the RAM and the stream
//   FIFO_PW    : FIFO pointer width (log2 of FIFO_DEPTH)
//   state_t    : controller state encoding
package ram_rd_streamer_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PW    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/ram_rd_streamer_if.sv
// Bundle of the streamer's command, RAM read port and output stream.
//   start/base_addr/len : burst command (into streamer)
//   busy/done           : burst status (out of streamer)
//   rd_addr/rd_en       : RAM read request (out of streamer)
//   rd_data             : RAM read data, one cycle after the request
//   m_data/m_valid      : output stream (out of streamer)
//   m_ready             : output stream backpressure (into streamer)
// master = the streamer, slave = its environment.
interface ram_rd_streamer_if #(
  parameter int AW = 8,
  parameter int DW = 32
) ();

  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  modport master (
    input  start, base_addr, len, rd_data, m_ready,
    output busy, done, rd_addr, rd_en, m_data, m_valid
  );

  modport slave (
    output start, base_addr, len, rd_data, m_ready,
    input  busy, done, rd_addr, rd_en, m_data, m_valid
  );

endinterface

// File: rtl/ram_rd_streamer_sync_fifo4.sv
// Depth-4 synchronous FIFO with registered storage.
//   clk, rst_n : clock, async active-low reset (clears pointers/occupancy)
//   push       : write push_data this cycle
//   pop        : remove head this cycle (ignored when empty)
//   head       : oldest word; valid when !empty
//   empty      : no words stored
//   occ        : number of stored words, 0..4
// A pushed word is only visible at the head from the next cycle (no bypass).
module sync_fifo4
  import ram_rd_streamer_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic [2:0]    occ
);

  logic [DW-1:0]      mem [FIFO_DEPTH];
  logic [FIFO_PW-1:0] wr_ptr;
  logic [FIFO_PW-1:0] rd_ptr;
  logic [2:0]         occ_q;
  logic               do_pop;

  assign do_pop = pop && (occ_q != 3'd0);
  assign head   = mem[rd_ptr];
  assign empty  = (occ_q == 3'd0);
  assign occ    = occ_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= 3'd0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   occ_q <= occ_q + 3'd1;
        2'b01:   occ_q <= occ_q - 3'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // The issuer reserves a slot for every in-flight read, so a push into a
  // full FIFO that is not simultaneously popped would mean that accounting broke.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !do_pop && occ_q == 3'(FIFO_DEPTH)))
    else $error("sync_fifo4 overflow");

endmodule

// File: rtl/ram_rd_streamer.sv
// Streams a burst of len words read from a 1-cycle-latency RAM, starting at
// base_addr (wrapping mod 2**AW), onto a valid/ready interface.
//   clk, rst_n : clock shared with the RAM, async active-low reset
//   bus        : ram_rd_streamer_if.master (command, status, RAM read port,
//                output stream)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start; command latched on start
// RUN    | issuing reads and streaming; leaves on the len-th handshake
// FINISH | one-cycle done pulse, then back to IDLE
module ram_rd_streamer
  import ram_rd_streamer_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_rd_streamer_if.master bus
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_RUN    = RUN;
  localparam logic [1:0] S_FINISH = FINISH;

  logic [1:0]    state;
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic [AW:0]   issued;
  logic [AW:0]   accepted;
  logic          inflight;

  logic [2:0]    occ;
  logic          empty;
  logic [DW-1:0] head;

  logic          issue;
  logic          beat;
  logic          last_beat;

  // Reads are throttled on FIFO occupancy plus the read still in the RAM
  // pipeline, never on m_ready, so every issued word has a slot waiting.
  assign issue = (state == S_RUN) && (issued < len_q) &&
                 (({1'b0, occ} + {3'b000, inflight}) < 4'(FIFO_DEPTH));

  assign beat      = bus.m_valid && bus.m_ready;
  assign last_beat = beat && (accepted == len_q - (AW+1)'(1));

  assign bus.rd_en   = issue;
  assign bus.rd_addr = base_q + issued[AW-1:0];
  assign bus.busy    = (state == S_RUN);
  assign bus.done    = (state == S_FINISH);
  assign bus.m_valid = !empty;
  assign bus.m_data  = head;

  sync_fifo4 #(.DW(DW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (bus.rd_data),
    .pop       (beat),
    .head      (head),
    .empty     (empty),
    .occ       (occ)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued   <= '0;
      accepted <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            base_q   <= bus.base_addr;
            len_q    <= bus.len;
            issued   <= '0;
            accepted <= '0;
            state    <= (bus.len == '0) ? S_FINISH : S_RUN;
          end
        end
        S_RUN: begin
          if (issue) issued   <= issued + (AW+1)'(1);
          if (beat)  accepted <= accepted + (AW+1)'(1);
          if (last_beat) state <= S_FINISH;
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Self-checking bench for ram_rd_streamer: a behavioural RAM plus a reference
// that expects word i of a burst to be ram_mem[(base+i) mod 256].
module tb_ram_rd_streamer;

  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_rd_streamer_if #(.AW(AW), .DW(DW)) bus ();

  ram_rd_streamer #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] ram_mem [256];
  always_ff @(posedge clk) bus.rd_data <= ram_mem[bus.rd_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 2) == 0;
      2:       return 1'($urandom_range(0, 1));
      default: return k > 10;
    endcase
  endfunction

  // mode: 0 ready=1, 1 toggling, 2 random, 3 stalled for cycles 0..10
  // rst_after > 0: pulse reset once that many beats have been seen
  task automatic run_burst(input logic [AW-1:0] base, input int n, input int mode,
                           input bit lat_chk, input bit poke, input int rst_after);
    int cyc, issues, beats, first_rd, first_val, last_b, done_cyc;
    bit stalled, aborted;
    logic [DW-1:0] held;
    logic [AW-1:0] exp_addr;
    issues = 0; beats = 0; first_rd = -1; first_val = -1; last_b = -1;
    done_cyc = -1; stalled = 0; aborted = 0; held = '0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.base_addr = base;
    bus.len = (AW+1)'(n);
    bus.m_ready = ready_for(mode, 0);
    cyc = 0;
    while (done_cyc < 0 && !aborted && cyc <= 2000) begin
      @(negedge clk);
      if (bus.rd_en) begin
        exp_addr = base + AW'(issues);
        chk("rd_addr", 64'(bus.rd_addr), 64'(exp_addr));
        if (first_rd < 0) first_rd = cyc;
        issues++;
      end
      if (stalled) begin
        chk("hold_valid", 64'(bus.m_valid), 64'(1));
        chk("hold_data", 64'(bus.m_data), 64'(held));
      end
      if (bus.m_valid && first_val < 0) first_val = cyc;
      if (bus.m_valid && bus.m_ready) begin
        exp_addr = base + AW'(beats);
        chk("beat_in_range", 64'(beats < n), 64'(1));
        chk("m_data", 64'(bus.m_data), 64'(ram_mem[exp_addr]));
        beats++;
        last_b = cyc;
      end
      stalled = bus.m_valid && !bus.m_ready;
      held = bus.m_data;
      if (mode == 3 && cyc == 10 && n >= 4) chk("stall_issues", 64'(issues), 64'(4));
      if (bus.done) begin
        done_cyc = cyc;
        chk("busy_at_done", 64'(bus.busy), 64'(0));
      end else if (cyc >= 1) begin
        chk("busy", 64'(bus.busy), 64'(n > 0));
      end
      if (rst_after > 0 && beats == rst_after && done_cyc < 0) begin
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("rst_m_valid", 64'(bus.m_valid), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_rd_en", 64'(bus.rd_en), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_rd_addr", 64'(bus.rd_addr), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
          @(negedge clk);
          chk("no_done_after_rst", 64'(bus.done), 64'(0));
          chk("idle_after_rst", 64'(bus.m_valid | bus.rd_en), 64'(0));
        end
        aborted = 1;
      end else if (done_cyc < 0) begin
        @(posedge clk); #1;
        cyc++;
        bus.start = poke && (cyc == ((n == 0) ? 1 : 2));
        if (bus.start) begin
          bus.base_addr = ~base;
          bus.len = (AW+1)'(3);
        end
        bus.m_ready = ready_for(mode, cyc);
      end
    end
    if (!aborted) begin
      if (done_cyc < 0) begin
        chk("timeout", 64'(0), 64'(1));
      end else begin
        chk("issues", 64'(issues), 64'(n));
        chk("beats", 64'(beats), 64'(n));
        if (n == 0) chk("done_len0", 64'(done_cyc), 64'(1));
        else        chk("done_timing", 64'(done_cyc), 64'(last_b + 1));
        if (lat_chk) begin
          chk("first_rd_en", 64'(first_rd), 64'(1));
          chk("first_valid", 64'(first_val), 64'(3));
        end
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.m_ready = 1'($urandom_range(0, 1));
      repeat (3) begin
        @(negedge clk);
        chk("post_idle", 64'(bus.rd_en | bus.m_valid | bus.done), 64'(0));
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.len = '0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 256; i++) ram_mem[i] = 32'h100 + 32'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_done", 64'(bus.done), 64'(0));
    chk("reset_m_valid", 64'(bus.m_valid), 64'(0));
    chk("reset_rd_en", 64'(bus.rd_en), 64'(0));
    chk("reset_rd_addr", 64'(bus.rd_addr), 64'(0));
    rst_n = 1'b1;

    run_burst(8'h10, 4, 0, 1'b1, 1'b0, 0);
    run_burst(8'hFE, 4, 0, 1'b0, 1'b0, 0);
    run_burst(8'h20, 4, 3, 1'b0, 1'b0, 0);
    run_burst(8'h30, 8, 1, 1'b0, 1'b0, 0);
    run_burst(8'h40, 0, 0, 1'b0, 1'b1, 0);
    run_burst(8'h50, 6, 0, 1'b0, 1'b1, 0);
    run_burst(8'h60, 8, 0, 1'b0, 1'b0, 2);
    run_burst(8'h70, 5, 0, 1'b1, 1'b0, 0);

    for (int i = 0; i < 256; i++) ram_mem[i] = $urandom;
    repeat (8) run_burst(AW'($urandom), $urandom_range(1, 24), $urandom_range(0, 2),
                         1'b0, 1'b0, 0);
    run_burst(8'hC3, 256, 0, 1'b0, 1'b0, 0);
    run_burst(8'h05, 256, 2, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
